trig_pulse_former: RTL and testbench

Multi-channel successor to the single-pair trigger output stage on the trigger board. It takes NCH deserialised LVDS sample words of NBINS bits each per `clkin` cycle and applies optional leading-edge vetoing and phase-offset bin selection. Each channel drives a trigger pulse with programmable firing width and dead time and keeps saturating raw-hit and accepted-fire counters with a synchronised clear. It sits between the LVDS deserialisers and the coax output/readout logic.

---
 rtl/trig_pkg.sv | 17 +
 rtl/trig_chan.sv | 135 +++++++++++++
 rtl/trig_pulse_former.sv | 99 +++++++++
 tb/tb_trig_pulse_former.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types and helpers for the multi-channel trigger pulse former.
// Optional passthrough is enabled by defining TRIG_PASSTHROUGH_EN.
package trig_pkg;

   typedef enum logic [1:0] {IDLE, FIRE, DEAD} trig_state_t;

   localparam int DEF_NCH   = 4;
   localparam int DEF_NBINS = 8;
   localparam int DEF_CNTW  = 32;
   localparam int TICKW     = 8;

   // One sample of the leading-edge stage: w is the sample, p the one just before it.
   function automatic logic edge_detect(input logic w, input logic p, input logic veto);
      return veto ? (w & ~p) : w;
   endfunction

endpackage

// File: rtl/trig_chan.sv
// One trigger channel: edge stage, hit register, non-retriggerable pulse FSM
// and the saturating raw-hit / fire counters.
module trig_chan
   import trig_pkg::*;
#(
   parameter int  NBINS = DEF_NBINS,
   parameter int  CNTW  = DEF_CNTW,
   localparam int PW    = $clog2(NBINS)
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic [NBINS-1:0] rx_word,
   input  logic [PW-1:0]    phaseoffset,
   input  logic             usefullwidth,
   input  logic             vetolast,
   input  logic [TICKW-1:0] firingticks,
   input  logic [TICKW-1:0] deadticks,
   input  logic             hold_idle,
   input  logic             clear,
   output logic             trig,
   output logic             busy,
   output logic [CNTW-1:0]  raw_cnt,
   output logic [CNTW-1:0]  fire_cnt
);

   logic [NBINS-1:0] prev_reg;
   logic [NBINS-1:0] edge_reg;
   logic [NBINS-1:0] edge_next;
   logic [NBINS:0]   edge_ext;
   logic [PW:0]      next_bin;
   logic             hit_reg;
   logic             hit_next;
   trig_state_t      state_reg;
   logic [TICKW-1:0] tick_reg;
   logic [TICKW-1:0] fire_load;
   logic             ready;
   logic             fire_start;

   genvar gi;
   generate
      for (gi = 0; gi < NBINS; gi++) begin : g_edge
         if (gi == 0) begin : g_first
            assign edge_next[gi] = edge_detect(rx_word[gi], prev_reg[NBINS-1], vetolast);
         end else begin : g_rest
            assign edge_next[gi] = edge_detect(rx_word[gi], rx_word[gi-1], vetolast);
         end
      end
   endgenerate

   // The zero guard bit above the word makes phaseoffset+1 at the top bin read 0 instead of wrapping.
   assign edge_ext = {1'b0, edge_reg};
   assign next_bin = {1'b0, phaseoffset} + {{PW{1'b0}}, 1'b1};
   assign hit_next = edge_reg[phaseoffset] | (usefullwidth & edge_ext[next_bin]);

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         prev_reg <= '0;
         edge_reg <= '0;
         hit_reg  <= 1'b0;
      end else begin
         prev_reg <= rx_word;
         edge_reg <= edge_next;
         hit_reg  <= hit_next;
      end
   end

   assign fire_load = (firingticks == '0) ? '0 : firingticks - 8'd1;

   // The last FIRE/DEAD cycle counts as the first idle cycle, so re-fire spacing is exactly firing+dead.
   assign ready = (state_reg == IDLE)
                | ((state_reg == DEAD) && (tick_reg == '0))
                | ((state_reg == FIRE) && (tick_reg == '0) && (deadticks == '0));
   assign fire_start = hit_reg & ready & ~hold_idle;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         trig      <= 1'b0;
         busy      <= 1'b0;
      end else if (hold_idle) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         trig      <= 1'b0;
         busy      <= 1'b0;
      end else if (fire_start) begin
         state_reg <= FIRE;
         tick_reg  <= fire_load;
         trig      <= 1'b1;
         busy      <= 1'b1;
      end else begin
         case (state_reg)
            FIRE: begin
               if (tick_reg == '0) begin
                  trig <= 1'b0;
                  if (deadticks == '0) begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end else begin
                     state_reg <= DEAD;
                     tick_reg  <= deadticks - 8'd1;
                  end
               end else begin
                  tick_reg <= tick_reg - 8'd1;
               end
            end
            DEAD: begin
               if (tick_reg == '0) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  tick_reg <= tick_reg - 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         raw_cnt  <= '0;
         fire_cnt <= '0;
      end else if (clear) begin
         raw_cnt  <= '0;
         fire_cnt <= '0;
      end else begin
         if (hit_reg && (raw_cnt != '1))
            raw_cnt <= raw_cnt + CNTW'(1);
         if (fire_start && (fire_cnt != '1))
            fire_cnt <= fire_cnt + CNTW'(1);
      end
   end

endmodule

// File: rtl/trig_pulse_former.sv
// Multi-channel trigger pulse former: per-channel pulse stages, counter clear
// synchroniser and histogram readout. TRIG_PASSTHROUGH_EN adds a raw passthrough mode.
module trig_pulse_former
   import trig_pkg::*;
#(
   parameter int  NCH   = DEF_NCH,
   parameter int  NBINS = DEF_NBINS,
   parameter int  CNTW  = DEF_CNTW,
   localparam int PW    = $clog2(NBINS),
   localparam int SW    = $clog2(2*NCH)
) (
   input  logic               clkin,
   input  logic               rst,
`ifdef TRIG_PASSTHROUGH_EN
   input  logic               passthrough,
`endif
   input  logic [NCH*NBINS-1:0] lvds_rx,
   input  logic [PW-1:0]      phaseoffset,
   input  logic               usefullwidth,
   input  logic               vetolast,
   input  logic [TICKW-1:0]   firingticks,
   input  logic [TICKW-1:0]   deadticks,
   input  logic               resethist,
   output logic [NCH-1:0]     trig_out,
   output logic [NCH-1:0]     busy,
   input  logic [SW-1:0]      hist_sel,
   output logic [CNTW-1:0]    hist_data
);

   logic            rh_meta_reg;
   logic            rh_sync_reg;
   logic            hold_idle;
   logic [NCH-1:0]  chan_trig;
   logic [NCH-1:0]  chan_busy;
   logic [CNTW-1:0] cnt_arr [2*NCH];

   // resethist is asynchronous to clkin; only the second flop is used.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         rh_meta_reg <= 1'b0;
         rh_sync_reg <= 1'b0;
      end else begin
         rh_meta_reg <= resethist;
         rh_sync_reg <= rh_meta_reg;
      end
   end

`ifdef TRIG_PASSTHROUGH_EN
   logic [NCH-1:0] pt_reg;

   assign hold_idle = passthrough;
   assign trig_out  = passthrough ? pt_reg : chan_trig;
   assign busy      = passthrough ? '0 : chan_busy;
`else
   assign hold_idle = 1'b0;
   assign trig_out  = chan_trig;
   assign busy      = chan_busy;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         trig_chan #(.NBINS(NBINS), .CNTW(CNTW)) u_chan (
            .clkin        (clkin),
            .rst          (rst),
            .rx_word      (lvds_rx[gi*NBINS +: NBINS]),
            .phaseoffset  (phaseoffset),
            .usefullwidth (usefullwidth),
            .vetolast     (vetolast),
            .firingticks  (firingticks),
            .deadticks    (deadticks),
            .hold_idle    (hold_idle),
            .clear        (rh_sync_reg),
            .trig         (chan_trig[gi]),
            .busy         (chan_busy[gi]),
            .raw_cnt      (cnt_arr[2*gi]),
            .fire_cnt     (cnt_arr[2*gi+1])
         );
`ifdef TRIG_PASSTHROUGH_EN
         always_ff @(posedge clkin or posedge rst) begin
            if (rst)
               pt_reg[gi] <= 1'b0;
            else
               pt_reg[gi] <= |lvds_rx[gi*NBINS +: NBINS];
         end
`endif
      end
   endgenerate

   always_ff @(posedge clkin or posedge rst) begin
      if (rst)
         hist_data <= '0;
      else if (int'(hist_sel) < 2*NCH)
         hist_data <= cnt_arr[hist_sel];
      else
         hist_data <= '0;
   end

endmodule

// File: tb/tb_trig_pulse_former.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// time-window reference model; a second CNTW=4 instance checks saturation.
module tb_trig_pulse_former;

   localparam int NCH = 4;
   localparam int NB  = 8;

   logic          clkin = 1'b0;
   logic          rst;
   logic [31:0]   lvds_rx;
   logic [2:0]    phaseoffset;
   logic          usefullwidth, vetolast;
   logic [7:0]    firingticks, deadticks;
   logic          resethist;
   logic [3:0]    trig_out, busy, trig_out_s, busy_s;
   logic [2:0]    hist_sel;
   logic [31:0]   hist_data;
   logic [3:0]    hist_data_s;

   int checks = 0;
   int errors = 0;

   always #5 clkin = ~clkin;

   trig_pulse_former #(.NCH(4), .NBINS(8), .CNTW(32)) dut (
      .clkin(clkin), .rst(rst),
`ifdef TRIG_PASSTHROUGH_EN
      .passthrough(1'b0),
`endif
      .lvds_rx(lvds_rx), .phaseoffset(phaseoffset), .usefullwidth(usefullwidth),
      .vetolast(vetolast), .firingticks(firingticks), .deadticks(deadticks),
      .resethist(resethist), .trig_out(trig_out), .busy(busy),
      .hist_sel(hist_sel), .hist_data(hist_data));

   trig_pulse_former #(.NCH(4), .NBINS(8), .CNTW(4)) dut_s (
      .clkin(clkin), .rst(rst),
`ifdef TRIG_PASSTHROUGH_EN
      .passthrough(1'b0),
`endif
      .lvds_rx(lvds_rx), .phaseoffset(phaseoffset), .usefullwidth(usefullwidth),
      .vetolast(vetolast), .firingticks(firingticks), .deadticks(deadticks),
      .resethist(resethist), .trig_out(trig_out_s), .busy(busy_s),
      .hist_sel(hist_sel), .hist_data(hist_data_s));

   // Reference model state: counts, pulse windows and the two-cycle hit/clear latency.
   longint      t;
   longint      fs [NCH];
   longint      nxt [NCH];
   longint      f_len [NCH];
   longint      d_len [NCH];
   longint      raw_m [NCH], fire_m [NCH], raw_s [NCH], fire_s [NCH];
   bit          hp0 [NCH], hp1 [NCH];
   bit          rp0, rp1;
   logic [7:0]  prev_w [NCH];
   logic [3:0]  exp_trig, exp_busy;
   logic [31:0] exp_hist;
   logic [3:0]  exp_hist_s;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hit(logic [7:0] w, logic [7:0] p, bit veto, int po, bit ufw);
      logic [7:0] e;
      for (int j = 0; j < NB; j++) begin
         if (!veto)       e[j] = w[j];
         else if (j == 0) e[j] = w[0] & ~p[7];
         else             e[j] = w[j] & ~w[j-1];
      end
      return e[po] | (ufw && po < NB-1 && e[po+1]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         fs[c] = -1000; nxt[c] = -1000; f_len[c] = 1; d_len[c] = 0;
         raw_m[c] = 0; fire_m[c] = 0; raw_s[c] = 0; fire_s[c] = 0;
         hp0[c] = 0; hp1[c] = 0; prev_w[c] = '0;
      end
      rp0 = 0; rp1 = 0;
      exp_trig = '0; exp_busy = '0; exp_hist = '0; exp_hist_s = '0;
   endtask

   task automatic model_edge();
      int  sc;
      bit  use_hit, clr, fired;
      sc = int'(hist_sel) / 2;
      exp_hist   = hist_sel[0] ? 32'(fire_m[sc]) : 32'(raw_m[sc]);
      exp_hist_s = hist_sel[0] ? 4'(fire_s[sc])  : 4'(raw_s[sc]);
      clr = rp1; rp1 = rp0; rp0 = resethist;
      for (int c = 0; c < NCH; c++) begin
         use_hit = hp1[c];
         hp1[c]  = hp0[c];
         hp0[c]  = model_hit(lvds_rx[c*NB +: NB], prev_w[c], vetolast, int'(phaseoffset), usefullwidth);
         prev_w[c] = lvds_rx[c*NB +: NB];
         fired = use_hit && (t >= nxt[c]);
         if (fired) begin
            fs[c]    = t;
            f_len[c] = (firingticks == 0) ? 1 : longint'(firingticks);
            d_len[c] = longint'(deadticks);
            nxt[c]   = t + f_len[c] + d_len[c];
         end
         if (clr) begin
            raw_m[c] = 0; fire_m[c] = 0; raw_s[c] = 0; fire_s[c] = 0;
         end else begin
            if (use_hit) begin
               raw_m[c]++;
               if (raw_s[c] < 15) raw_s[c]++;
            end
            if (fired) begin
               fire_m[c]++;
               if (fire_s[c] < 15) fire_s[c]++;
            end
         end
         exp_trig[c] = (t >= fs[c]) && (t < fs[c] + f_len[c]);
         exp_busy[c] = (t >= fs[c]) && (t < fs[c] + f_len[c] + d_len[c]);
      end
      t++;
   endtask

   task automatic step();
      @(posedge clkin);
      if (!rst) model_edge();
      #1;
      check_val("trig_out", trig_out, exp_trig);
      check_val("busy", busy, exp_busy);
      check_val("hist_data", hist_data, exp_hist);
      check_val("trig_out_c4", trig_out_s, exp_trig);
      check_val("busy_c4", busy_s, exp_busy);
      check_val("hist_data_c4", hist_data_s, exp_hist_s);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_trig", trig_out, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_hist", hist_data, 0);
      check_val("rst_hist_c4", hist_data_s, 0);
      model_reset();
      @(posedge clkin);
      #1 rst = 1'b0;
   endtask

   task automatic set_word(input int c, input logic [7:0] v);
      lvds_rx[c*NB +: NB] = v;
   endtask

   initial begin
      int first, tcnt, bcnt;
      logic [15:0] mask;
      rst = 1'b1; lvds_rx = '0; phaseoffset = '0; usefullwidth = 0; vetolast = 0;
      firingticks = 8'd3; deadticks = 8'd2; resethist = 0; hist_sel = '0; t = 0;
      model_reset();
      repeat (2) @(posedge clkin);
      #1;
      check_val("reset_trig", trig_out, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_hist", hist_data, 0);
      rst = 1'b0;

      // Single pulse: trig for 3 cycles from k+2, busy for 5.
      first = -1; tcnt = 0; bcnt = 0;
      set_word(0, 8'h01);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 0) set_word(0, 8'h00);
         if (trig_out[0]) begin tcnt++; if (first < 0) first = i; end
         if (busy[0]) bcnt++;
      end
      check_val("s1_first", first, 2);
      check_val("s1_trig_len", tcnt, 3);
      check_val("s1_busy_len", bcnt, 5);
      hist_sel = 3'd0; step(); check_val("s1_raw", hist_data, 1);
      hist_sel = 3'd1; step(); check_val("s1_fire", hist_data, 1);

      // Leading-edge veto.
      do_reset();
      vetolast = 1; phaseoffset = 3'd2; hist_sel = 3'd2;
      set_word(1, 8'hFF);
      repeat (3) step();
      set_word(1, 8'h00);
      repeat (4) step();
      check_val("s2_veto_ff", hist_data, 0);
      set_word(1, 8'h04); step(); set_word(1, 8'h00);
      repeat (4) step();
      check_val("s2_edge_04", hist_data, 1);

      // Full width at the top bin, no wrap.
      do_reset();
      vetolast = 0; usefullwidth = 1; phaseoffset = 3'd7; hist_sel = 3'd4;
      set_word(2, 8'h80); step(); set_word(2, 8'h00);
      repeat (4) step();
      check_val("s3_top_bin", hist_data, 1);
      set_word(2, 8'h01); step(); set_word(2, 8'h00);
      repeat (4) step();
      check_val("s3_no_wrap", hist_data, 1);

      // Non-retriggerable spacing.
      do_reset();
      usefullwidth = 0; phaseoffset = 3'd0; firingticks = 8'd1; deadticks = 8'd3; hist_sel = 3'd6;
      mask = '0;
      set_word(3, 8'h01);
      for (int i = 0; i < 16; i++) begin
         step();
         if (i == 9) set_word(3, 8'h00);
         mask[i] = trig_out[3];
      end
      check_val("s4_fire_mask", mask, 16'h0444);
      check_val("s4_raw", hist_data, 10);
      hist_sel = 3'd7; step(); check_val("s4_fire", hist_data, 3);

      // Counter clear while hits stream in, then reset mid-FIRE.
      do_reset();
      firingticks = 8'd1; deadticks = 8'd0; hist_sel = 3'd1;
      set_word(0, 8'h01);
      repeat (5) step();
      resethist = 1;
      repeat (4) step();
      check_val("s5_clear4", hist_data, 0);
      repeat (2) step();
      resethist = 0;
      repeat (8) step();
      check_val("s5_resume", hist_data != 0, 1);
      set_word(0, 8'h00);
      repeat (4) step();
      firingticks = 8'd8; deadticks = 8'd2;
      set_word(0, 8'h01); step(); set_word(0, 8'h00);
      repeat (2) step();
      check_val("s5_fire", trig_out[0], 1);
      do_reset();
      for (int s = 0; s < 8; s++) begin
         hist_sel = 3'(s); step();
         check_val("s5_zero", hist_data, 0);
      end

      // Saturation of the narrow counters.
      firingticks = 8'd1; deadticks = 8'd0; hist_sel = 3'd0;
      set_word(0, 8'h01);
      repeat (20) step();
      set_word(0, 8'h00);
      repeat (3) step();
      check_val("s6_sat_c4", hist_data_s, 15);
      check_val("s6_raw_c32", hist_data, 20);

      // Randomized traffic; configuration changes only after a quiet gap.
      for (int blk = 0; blk < 10; blk++) begin
         lvds_rx = '0; resethist = 0;
         repeat (12) step();
         phaseoffset  = 3'($urandom_range(0, 7));
         usefullwidth = 1'($urandom_range(0, 1));
         vetolast     = 1'($urandom_range(0, 1));
         firingticks  = 8'($urandom_range(0, 5));
         deadticks    = 8'($urandom_range(0, 4));
         if (blk == 5) do_reset();
         for (int i = 0; i < 40; i++) begin
            lvds_rx  = $urandom & $urandom & $urandom;
            hist_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) resethist = ~resethist;
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
